// File: rtl/key_press_classifier.sv
// Per-key press classifier: turns debounced key levels into one-cycle
// short-press, long-press and double-click event pulses. A single shared
// divider produces the timing tick. Each key runs its own small FSM with an
// 8-bit tick counter.
module key_press_classifier #(
    parameter int N_KEYS     = 2,
    parameter int TICK_DIV   = 1_000_000,
    parameter int LONG_TICKS = 50,
    parameter int DBL_TICKS  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_lvl,
    output logic [N_KEYS-1:0] short_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] dbl_pulse,
    output logic              evt_any
);

    localparam int              TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_MAX = TW'(TICK_DIV - 1);
    // Thresholds are compared against cnt+1, held one bit wider than cnt.
    localparam logic [8:0]      LONG_CMP = 9'(LONG_TICKS);
    localparam logic [8:0]      DBL_CMP  = 9'(DBL_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_WAIT2,
        S_PRESS2,
        S_LHOLD
    } state_t;

    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [N_KEYS-1:0] short_d;
    logic [N_KEYS-1:0] long_d;
    logic [N_KEYS-1:0] dbl_d;

    // Free-running divider; tick marks the cycle on which it wraps.
    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_MAX);

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        state_t     state_q;
        state_t     state_d;
        logic [7:0] cnt_q;
        logic [7:0] cnt_d;
        logic [8:0] cnt_p1;
        logic       short_nx;
        logic       long_nx;
        logic       dbl_nx;

        assign cnt_p1 = {1'b0, cnt_q} + 9'd1;

        // Next state, event strobes and tick counter for this key.
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        always_comb begin
            state_d  = state_q;
            short_nx = 1'b0;
            long_nx  = 1'b0;
            dbl_nx   = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!key_lvl[k]) state_d = S_PRESS1;
                end
                S_PRESS1: begin
                    // The long threshold takes precedence over a release on the same edge.
                    if (tick && cnt_p1 == LONG_CMP) begin
                        long_nx = 1'b1;
                        state_d = key_lvl[k] ? S_IDLE : S_LHOLD;
                    end else if (key_lvl[k]) begin
                        state_d = S_WAIT2;
                    end
                end
                S_WAIT2: begin
                    // A second press beats the gap expiring on the same edge.
                    if (!key_lvl[k]) begin
                        dbl_nx  = 1'b1;
                        state_d = S_PRESS2;
                    end else if (tick && cnt_p1 == DBL_CMP) begin
                        short_nx = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_PRESS2, S_LHOLD: begin
                    if (key_lvl[k]) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            if (state_d != state_q) begin
                cnt_d = '0;
            end else if (tick && cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end

        // State and tick-count registers for this key.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign short_d[k] = short_nx;
        assign long_d[k]  = long_nx;
        assign dbl_d[k]   = dbl_nx;
    end

    // Register the event strobes so each pulse is glitch-free and one cycle wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            short_pulse <= '0;
            long_pulse  <= '0;
            dbl_pulse   <= '0;
            evt_any     <= 1'b0;
        end else begin
            short_pulse <= short_d;
            long_pulse  <= long_d;
            dbl_pulse   <= dbl_d;
            evt_any     <= |{short_d, long_d, dbl_d};
        end
    end

endmodule

// File: tb/tb_key_press_classifier.sv
// Directed bench for key_press_classifier with TICK_DIV=4, LONG_TICKS=8,
// DBL_TICKS=3. Each scenario resets the DUT, drives key levels per clock
// edge (edge 1 is the first edge after reset release), logs every pulse and
// compares the log with hand-derived cycle numbers. Ticks land on edges 4,8,..
module tb_key_press_classifier;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] key_lvl;
    logic [1:0] short_pulse;
    logic [1:0] long_pulse;
    logic [1:0] dbl_pulse;
    logic       evt_any;

    int tests_run = 0;
    int tests_failed = 0;

    // Pulse log of the last run: counts and edge number of the first pulse.
    int n_short[2], t_short[2], n_long[2], t_long[2], n_dbl[2], t_dbl[2];
    int n_evt, t_evt;

    key_press_classifier #(
        .N_KEYS    (2),
        .TICK_DIV  (4),
        .LONG_TICKS(8),
        .DBL_TICKS (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_lvl    (key_lvl),
        .short_pulse(short_pulse),
        .long_pulse (long_pulse),
        .dbl_pulse  (dbl_pulse),
        .evt_any    (evt_any)
    );

    always #5 clk = ~clk;

    // Key level at edge e: pressed (0) during [a,b) and [c,d).
    function automatic logic lvl(input int e, input int a, input int b, input int c, input int d);
        return !((e >= a && e < b) || (e >= c && e < d));
    endfunction

    function automatic int n_total();
        return n_short[0] + n_short[1] + n_long[0] + n_long[1] + n_dbl[0] + n_dbl[1];
    endfunction

    // Reset, then run n edges with the two key patterns, logging pulses.
    task automatic run(input int n,
                       input int a0, input int b0, input int c0, input int d0,
                       input int a1, input int b1, input int c1, input int d1);
        rst_n   = 1'b0;
        key_lvl = 2'b11;
        for (int k = 0; k < 2; k++) begin
            n_short[k] = 0; t_short[k] = -1;
            n_long[k]  = 0; t_long[k]  = -1;
            n_dbl[k]   = 0; t_dbl[k]   = -1;
        end
        n_evt = 0; t_evt = -1;
        repeat (2) @(posedge clk);
        #1;
        key_lvl = {lvl(1, a1, b1, c1, d1), lvl(1, a0, b0, c0, d0)};
        rst_n   = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (short_pulse[k]) begin if (n_short[k] == 0) t_short[k] = c; n_short[k]++; end
                if (long_pulse[k])  begin if (n_long[k] == 0)  t_long[k]  = c; n_long[k]++;  end
                if (dbl_pulse[k])   begin if (n_dbl[k] == 0)   t_dbl[k]   = c; n_dbl[k]++;   end
            end
            if (evt_any) begin if (n_evt == 0) t_evt = c; n_evt++; end
            key_lvl = {lvl(c + 1, a1, b1, c1, d1), lvl(c + 1, a0, b0, c0, d0)};
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        key_lvl = 2'b11;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({short_pulse, long_pulse, dbl_pulse, evt_any} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset/outputs: got %b, want 0000000", {short_pulse, long_pulse, dbl_pulse, evt_any});
        end
    endtask

    task automatic test_short_press();
        run(40, 1, 11, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (n_short[0] !== 1 || t_short[0] !== 20) begin
            tests_failed++;
            $display("FAIL short_press/short0: got n=%0d at %0d, want n=1 at 20", n_short[0], t_short[0]);
        end
        tests_run++;
        if (n_total() !== 1) begin
            tests_failed++;
            $display("FAIL short_press/total: got %0d pulses, want 1", n_total());
        end
        tests_run++;
        if (n_evt !== 1 || t_evt !== 20) begin
            tests_failed++;
            $display("FAIL short_press/evt_any: got n=%0d at %0d, want n=1 at 20", n_evt, t_evt);
        end
    endtask

    task automatic test_long_press();
        run(70, 0, 0, 0, 0, 1, 61, 0, 0);
        tests_run++;
        if (n_long[1] !== 1 || t_long[1] !== 32) begin
            tests_failed++;
            $display("FAIL long_press/long1: got n=%0d at %0d, want n=1 at 32", n_long[1], t_long[1]);
        end
        tests_run++;
        if (n_total() !== 1 || n_short[1] !== 0) begin
            tests_failed++;
            $display("FAIL long_press/total: got %0d pulses (short1=%0d), want 1 (short1=0)", n_total(), n_short[1]);
        end
    endtask

    task automatic test_double_click();
        run(50, 1, 9, 15, 23, 0, 0, 0, 0);
        tests_run++;
        if (n_dbl[0] !== 1 || t_dbl[0] !== 15) begin
            tests_failed++;
            $display("FAIL double_click/dbl0: got n=%0d at %0d, want n=1 at 15", n_dbl[0], t_dbl[0]);
        end
        tests_run++;
        if (n_total() !== 1 || n_short[0] !== 0) begin
            tests_failed++;
            $display("FAIL double_click/total: got %0d pulses (short0=%0d), want 1 (short0=0)", n_total(), n_short[0]);
        end
    endtask

    task automatic test_collision_long_release();
        run(60, 1, 32, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (n_long[0] !== 1 || t_long[0] !== 32) begin
            tests_failed++;
            $display("FAIL collision_a/long0: got n=%0d at %0d, want n=1 at 32", n_long[0], t_long[0]);
        end
        tests_run++;
        if (n_total() !== 1) begin
            tests_failed++;
            $display("FAIL collision_a/total: got %0d pulses, want 1", n_total());
        end
    endtask

    task automatic test_collision_press_expiry();
        run(40, 1, 3, 12, 16, 0, 0, 0, 0);
        tests_run++;
        if (n_dbl[0] !== 1 || t_dbl[0] !== 12) begin
            tests_failed++;
            $display("FAIL collision_b/dbl0: got n=%0d at %0d, want n=1 at 12", n_dbl[0], t_dbl[0]);
        end
        tests_run++;
        if (n_total() !== 1) begin
            tests_failed++;
            $display("FAIL collision_b/total: got %0d pulses, want 1", n_total());
        end
    endtask

    task automatic test_press2_no_long();
        run(70, 1, 5, 9, 59, 0, 0, 0, 0);
        tests_run++;
        if (n_dbl[0] !== 1 || t_dbl[0] !== 9 || n_total() !== 1) begin
            tests_failed++;
            $display("FAIL press2_no_long: got dbl0 n=%0d at %0d total=%0d, want n=1 at 9 total=1",
                     n_dbl[0], t_dbl[0], n_total());
        end
    endtask

    task automatic test_parallel_keys();
        run(60, 1, 11, 0, 0, 1, 41, 0, 0);
        tests_run++;
        if (t_short[0] !== 20 || t_long[1] !== 32 || n_total() !== 2) begin
            tests_failed++;
            $display("FAIL parallel/events: got short0@%0d long1@%0d total=%0d, want short0@20 long1@32 total=2",
                     t_short[0], t_long[1], n_total());
        end
        tests_run++;
        if (n_evt !== 2 || t_evt !== 20) begin
            tests_failed++;
            $display("FAIL parallel/evt_any: got n=%0d at %0d, want n=2 at 20", n_evt, t_evt);
        end
    endtask

    task automatic test_back_to_back();
        run(40, 1, 11, 0, 0, 1, 11, 0, 0);
        tests_run++;
        if (n_short[0] !== 1 || n_short[1] !== 1 || t_short[0] !== 20 || t_short[1] !== 20 || n_total() !== 2) begin
            tests_failed++;
            $display("FAIL same_cycle/short: got short0@%0d short1@%0d total=%0d, want both @20 total=2",
                     t_short[0], t_short[1], n_total());
        end
        tests_run++;
        if (n_evt !== 1 || t_evt !== 20) begin
            tests_failed++;
            $display("FAIL same_cycle/evt_any: got n=%0d at %0d, want n=1 at 20", n_evt, t_evt);
        end
    endtask

    task automatic test_reset_mid_sequence();
        // Live pulse is cleared immediately by reset assertion.
        run(20, 1, 11, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (n_short[0] !== 1 || {short_pulse, evt_any} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_live_pulse: got n=%0d out=%b, want n=1 out=000", n_short[0], {short_pulse, evt_any});
        end
        // Reset while key0 sits in PRESS1, then release with the key up.
        run(5, 1, 100, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({short_pulse, long_pulse, dbl_pulse, evt_any} !== 7'b0 || n_total() !== 0) begin
            tests_failed++;
            $display("FAIL reset_press1/outputs: got %b total=%0d, want 0000000 total=0",
                     {short_pulse, long_pulse, dbl_pulse, evt_any}, n_total());
        end
        run(40, 0, 0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (n_total() !== 0 || n_evt !== 0) begin
            tests_failed++;
            $display("FAIL reset_press1/after: got %0d pulses evt=%0d, want 0", n_total(), n_evt);
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_press();
        test_double_click();
        test_collision_long_release();
        test_collision_press_expiry();
        test_press2_no_long();
        test_parallel_keys();
        test_back_to_back();
        test_reset_mid_sequence();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/key_press_classifier.md
KEY_PRESS_CLASSIFIER -- requirements
Module: key_press_classifier

Interface
REQ-001 Parameter N_KEYS, default 2: number of independent key channels.
REQ-002 Parameter TICK_DIV, default 1_000_000: clk cycles per timing tick (20 ms at 50 MHz).
REQ-003 Parameter LONG_TICKS, default 50: held ticks that qualify a long press (1 s).
REQ-004 Parameter DBL_TICKS, default 15: maximum release gap, in ticks, for a double click (300 ms).
REQ-005 Port clk, input, 1: system clock, all logic on rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port key_lvl, input, N_KEYS: debounced key level, same clk domain, 0 = pressed, 1 = released.
REQ-008 Port short_pulse, output, N_KEYS: per-key single short press event.
REQ-009 Port long_pulse, output, N_KEYS: per-key long press event.
REQ-010 Port dbl_pulse, output, N_KEYS: per-key double click event.
REQ-011 Port evt_any, output, 1: OR of all event pulses, registered.

Function
REQ-012 Shared free-running tick counter 0..TICK_DIV-1; tick is high for one cycle when it wraps; first tick occurs TICK_DIV cycles after reset release.
REQ-013 Each key has an independent FSM with states IDLE, PRESS1, WAIT2, PRESS2 and LHOLD, plus an 8-bit tick counter cnt.
REQ-014 cnt clears on every state change, increments on tick only and saturates at 255.
REQ-015 IDLE: key_lvl=0 -> PRESS1.
REQ-016 PRESS1, threshold case: tick with cnt+1 == LONG_TICKS -> long_pulse; next state is LHOLD if key_lvl=0, else IDLE.
REQ-017 PRESS1, release case: key_lvl=1 without a threshold tick -> WAIT2.
REQ-018 PRESS1, simultaneous threshold tick and release: long_pulse wins.
REQ-019 WAIT2: key_lvl=0 -> dbl_pulse, go to PRESS2.
REQ-020 WAIT2: tick with cnt+1 == DBL_TICKS and key_lvl=1 -> short_pulse, go to IDLE.
REQ-021 WAIT2, simultaneous press and expiry tick: press wins, so dbl_pulse is emitted and no short_pulse.
REQ-022 PRESS2: no long detection; key_lvl=1 -> IDLE.
REQ-023 LHOLD: key_lvl=1 -> IDLE; no further events while held.
REQ-024 Event pulse timing: each pulse is registered, high for exactly one clk cycle, and starts the cycle after the edge that takes the transition.
REQ-025 Event exclusivity: at most one event per key per press sequence.
REQ-026 Channel independence: channels never interact; simultaneous events on several keys are all reported in the same cycle.
REQ-027 Timing resolution is quantised to +/-1 tick by the shared divider; this is accepted behaviour.

Reset
REQ-028 While rst_n=0: all FSMs in IDLE, cnt=0, tick counter=0, and short_pulse, long_pulse, dbl_pulse, evt_any all 0.
REQ-029 Reset asserted mid-sequence in any state aborts the sequence with no pulse emitted.
REQ-030 After reset release, a key already held (key_lvl=0) is treated as a fresh press (IDLE -> PRESS1).

Verification (TICK_DIV=4, LONG_TICKS=8, DBL_TICKS=3, N_KEYS=2)
REQ-031 Short press: key0 low for 10 cycles then high -> exactly one short_pulse[0] 3 ticks after release (12 clk +/-4); no other pulses.
REQ-032 Long press: key1 held low 60 cycles -> long_pulse[1] on the 8th tick after the press; none on release; short_pulse[1]=0.
REQ-033 Double click: key0 low 8, high 6, low 8, high -> dbl_pulse[0] one cycle after the second falling level; no short_pulse[0] at any point.
REQ-034 Collision case A: release coinciding with the 8th tick -> long_pulse only.
REQ-035 Collision case B: second press coinciding with the 3rd WAIT2 tick -> dbl_pulse only.
REQ-036 Parallel keys and reset: key0 short press and key1 long press overlapping -> both pulses reported independently; rst_n pulsed low during PRESS1 -> no event, all outputs 0, FSM back in IDLE.
